// File: rtl/mux_nx1_rr.sv
// mux_nx1_rr: N-to-1 registered multiplexer with valid/ready handshake.
//   Selects one of N producer channels, either by a fixed external selector
//   (mode = 0) or by round-robin arbitration among valid channels (mode = 1),
//   and holds the chosen word in a one-entry output register that honours
//   downstream backpressure.
//
// Ports
//   clk        rising-edge clock
//   reset_L    asynchronous reset, active low
//   mode       0 = fixed selector, 1 = round-robin
//   selector   channel index used in fixed mode (values >= N never grant)
//   data_in    N packed channels, channel k at [k*W +: W]
//   valid_in   per-channel valid
//   ready_in   one-hot accept strobe (combinational, depends on ready_out)
//   data_out   registered output word
//   valid_out  data_out holds a word not yet taken
//   sel_out    channel index data_out came from
//   ready_out  consumer accepts data_out when valid_out is high
module mux_nx1_rr #(
  parameter int unsigned W     = 2,
  parameter int unsigned N     = 4,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             mode,
  input  logic [SEL_W-1:0] selector,
  input  logic [N*W-1:0]   data_in,
  input  logic [N-1:0]     valid_in,
  output logic [N-1:0]     ready_in,
  output logic [W-1:0]     data_out,
  output logic             valid_out,
  output logic [SEL_W-1:0] sel_out,
  input  logic             ready_out
);

  // One extra bit so ptr + offset (at most 2N-2) never wraps before the modulo.
  localparam int unsigned IDX_W = SEL_W + 1;

  logic             load_c;
  logic             gnt_vld_c;
  logic [SEL_W-1:0] gnt_idx_c;
  logic [W-1:0]     gnt_data_c;
  logic [SEL_W-1:0] ptr_nxt_c;
  logic [IDX_W-1:0] scan_c;
  logic [SEL_W-1:0] ptr_q;

  // Output register may take a new word when empty or being drained.
  assign load_c = !valid_out || ready_out;

  // Grant selection: fixed index or first valid channel at/after the pointer.
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_idx_c = '0;
    scan_c    = '0;
    if (!mode) begin
      // Comparing against every legal index means an out-of-range selector
      // simply matches nothing.
      for (int unsigned k = 0; k < N; k++) begin
        if (selector == SEL_W'(k) && valid_in[k]) begin
          gnt_vld_c = 1'b1;
          gnt_idx_c = SEL_W'(k);
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        scan_c = {1'b0, ptr_q} + IDX_W'(i);
        if (scan_c >= IDX_W'(N)) begin
          scan_c = scan_c - IDX_W'(N);
        end
        if (!gnt_vld_c && valid_in[scan_c[SEL_W-1:0]]) begin
          gnt_vld_c = 1'b1;
          gnt_idx_c = scan_c[SEL_W-1:0];
        end
      end
    end
  end

  // Data mux for the granted channel.
  always_comb begin
    gnt_data_c = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (gnt_idx_c == SEL_W'(k)) begin
        gnt_data_c = data_in[k*W +: W];
      end
    end
  end

  // Accept strobe; forced low while reset is held so nothing is taken.
  always_comb begin
    ready_in = '0;
    if (reset_L && load_c && gnt_vld_c) begin
      ready_in[gnt_idx_c] = 1'b1;
    end
  end

  // Pointer moves to the channel just after the accepted one.
  always_comb begin
    ptr_nxt_c = gnt_idx_c + SEL_W'(1);
    if (gnt_idx_c == SEL_W'(N - 1)) begin
      ptr_nxt_c = '0;
    end
  end

  // Output register; data/sel keep their last value when nothing is granted.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      sel_out   <= '0;
    end else if (load_c) begin
      if (gnt_vld_c) begin
        data_out  <= gnt_data_c;
        valid_out <= 1'b1;
        sel_out   <= gnt_idx_c;
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

  // Round-robin pointer advances only on an accepted round-robin grant.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q <= '0;
    end else if (load_c && gnt_vld_c && mode) begin
      ptr_q <= ptr_nxt_c;
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Bench for mux_nx1_rr: directed vector table, hand-written corner sequences
// (async reset, mode switch, out-of-range selector on an N=3 instance) and a
// randomized phase checked against a queue-free transaction model.
module tb_mux_nx1_rr;

  localparam int unsigned N = 4;

  logic       clk;
  logic       reset_L;
  logic       mode;
  logic [1:0] selector;
  logic [7:0] data_in;
  logic [3:0] valid_in;
  logic [3:0] ready_in;
  logic [1:0] data_out;
  logic       valid_out;
  logic [1:0] sel_out;
  logic       ready_out;

  logic       mode3;
  logic [1:0] selector3;
  logic [5:0] data_in3;
  logic [2:0] valid_in3;
  logic [2:0] ready_in3;
  logic [1:0] data_out3;
  logic       valid_out3;
  logic [1:0] sel_out3;
  logic       ready_out3;

  mux_nx1_rr #(.W(2), .N(4)) dut (
    .clk(clk), .reset_L(reset_L), .mode(mode), .selector(selector),
    .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .data_out(data_out), .valid_out(valid_out), .sel_out(sel_out),
    .ready_out(ready_out)
  );

  mux_nx1_rr #(.W(2), .N(3)) dut3 (
    .clk(clk), .reset_L(reset_L), .mode(mode3), .selector(selector3),
    .data_in(data_in3), .valid_in(valid_in3), .ready_in(ready_in3),
    .data_out(data_out3), .valid_out(valid_out3), .sel_out(sel_out3),
    .ready_out(ready_out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the N=4 instance.
  int         m_ptr;
  bit         m_valid;
  int         m_data;
  int         m_sel;
  logic [3:0] m_rdy;

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
  endtask

  function automatic int ref_grant();
    if (!mode) begin
      if (valid_in[selector]) return int'(selector);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (valid_in[c]) return c;
    end
    return -1;
  endfunction

  // Settle combinational logic after inputs change, compute expected strobe.
  task automatic pre_edge();
    int g;
    #2;
    g = ref_grant();
    m_rdy = ((!m_valid || ready_out) && g >= 0) ? 4'(1 << g) : 4'b0000;
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic do_edge();
    int g;
    bit load;
    g    = ref_grant();
    load = !m_valid || ready_out;
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        m_data  = int'(data_in[g*2 +: 2]);
        m_valid = 1;
        m_sel   = g;
        if (mode) m_ptr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic step_chk(input string name, input logic [3:0] e_rdy, input logic e_vout,
                          input logic [1:0] e_dout, input logic [1:0] e_sel);
    pre_edge();
    chk({name, ".ready_in"}, 32'(ready_in), 32'(e_rdy));
    do_edge();
    chk({name, ".valid_out"}, 32'(valid_out), 32'(e_vout));
    chk({name, ".data_out"}, 32'(data_out), 32'(e_dout));
    chk({name, ".sel_out"}, 32'(sel_out), 32'(e_sel));
  endtask

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] vin;
    logic [7:0] din;
    logic       rout;
    logic [3:0] e_rdy;
    logic       e_vout;
    logic [1:0] e_dout;
    logic [1:0] e_sel;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int exp_seq[4];
    // Fixed mode, round-robin sweeps and a backpressure window; channel k
    // carries value k (8'he4) outside the first two vectors.
    tbl[0]  = '{1'b0, 2'd2, 4'b0100, 8'h20, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
    tbl[1]  = '{1'b0, 2'd2, 4'b0000, 8'h20, 1'b1, 4'b0000, 1'b0, 2'd2, 2'd2};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, 8'he4, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 8'he4, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 8'he4, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 8'he4, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
    tbl[6]  = '{1'b1, 2'd0, 4'b1111, 8'he4, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
    tbl[7]  = '{1'b1, 2'd0, 4'b1111, 8'he4, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
    tbl[8]  = '{1'b1, 2'd0, 4'b1010, 8'he4, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
    tbl[9]  = '{1'b1, 2'd0, 4'b1010, 8'he4, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
    tbl[10] = '{1'b1, 2'd0, 4'b1010, 8'he4, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
    tbl[11] = '{1'b1, 2'd0, 4'b1010, 8'he4, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
    tbl[12] = '{1'b1, 2'd0, 4'b1111, 8'he4, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd1};
    tbl[13] = '{1'b1, 2'd0, 4'b1111, 8'he4, 1'b0, 4'b0000, 1'b1, 2'd1, 2'd1};
    tbl[14] = '{1'b1, 2'd0, 4'b1111, 8'he4, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};

    reset_L = 1'b0;
    mode = 0; selector = 0; data_in = 0; valid_in = 0; ready_out = 0;
    mode3 = 0; selector3 = 0; data_in3 = 0; valid_in3 = 0; ready_out3 = 0;
    model_reset();

    #1;
    chk("reset.valid_out", 32'(valid_out), 0);
    chk("reset.data_out", 32'(data_out), 0);
    chk("reset.sel_out", 32'(sel_out), 0);
    chk("reset.ready_in", 32'(ready_in), 0);

    @(posedge clk); #1;
    reset_L = 1'b1;

    for (int i = 0; i < 15; i++) begin
      mode = tbl[i].mode; selector = tbl[i].sel; valid_in = tbl[i].vin;
      data_in = tbl[i].din; ready_out = tbl[i].rout;
      step_chk($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_vout, tbl[i].e_dout, tbl[i].e_sel);
    end

    // Async reset mid-stream while a 2'b11 word is held.
    mode = 0; selector = 3; valid_in = 4'b1000; data_in = 8'hc0; ready_out = 1;
    step_chk("hold11", 4'b1000, 1'b1, 2'd3, 2'd3);
    ready_out = 0; mode = 1; valid_in = 4'b1111; data_in = 8'he4;
    reset_L = 1'b0;
    model_reset();
    #1;
    chk("async.valid_out", 32'(valid_out), 0);
    chk("async.data_out", 32'(data_out), 0);
    chk("async.sel_out", 32'(sel_out), 0);
    chk("async.ready_in", 32'(ready_in), 0);
    reset_L = 1'b1;
    ready_out = 1;
    step_chk("post_reset", 4'b0001, 1'b1, 2'd0, 2'd0);
    exp_seq = '{1, 3, 1, 3};
    valid_in = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step_chk($sformatf("rr1010_%0d", i), 4'(1 << exp_seq[i]), 1'b1,
               2'(exp_seq[i]), 2'(exp_seq[i]));
    end

    // Mode switch: park ptr at 3, use fixed mode twice, then round-robin again.
    valid_in = 4'b0100;
    step_chk("ptr_to3", 4'b0100, 1'b1, 2'd2, 2'd2);
    mode = 0; selector = 1; valid_in = 4'b1111;
    step_chk("fixed_a", 4'b0010, 1'b1, 2'd1, 2'd1);
    step_chk("fixed_b", 4'b0010, 1'b1, 2'd1, 2'd1);
    mode = 1;
    step_chk("rr_resume", 4'b1000, 1'b1, 2'd3, 2'd3);

    // N=3 instance: out-of-range selector never grants.
    mode3 = 0; selector3 = 0; valid_in3 = 3'b111; data_in3 = 6'b10_01_11; ready_out3 = 1;
    pre_edge();
    chk("n3.ready_in_a", 32'(ready_in3), 32'(3'b001));
    do_edge();
    chk("n3.valid_a", 32'(valid_out3), 1);
    chk("n3.data_a", 32'(data_out3), 3);
    selector3 = 3; ready_out3 = 0;
    pre_edge();
    chk("n3.ready_in_b", 32'(ready_in3), 0);
    do_edge();
    chk("n3.valid_b", 32'(valid_out3), 1);
    ready_out3 = 1;
    pre_edge();
    chk("n3.ready_in_c", 32'(ready_in3), 0);
    do_edge();
    chk("n3.valid_c", 32'(valid_out3), 0);
    chk("n3.data_c", 32'(data_out3), 3);
    chk("n3.sel_c", 32'(sel_out3), 0);

    // Randomized traffic against the model, with occasional async resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset_L = 1'b0;
        model_reset();
        #1;
        chk("rnd.reset_valid", 32'(valid_out), 0);
        reset_L = 1'b1;
      end
      mode      = 1'($urandom_range(0, 1));
      selector  = 2'($urandom_range(0, 3));
      valid_in  = 4'($urandom);
      data_in   = 8'($urandom);
      ready_out = ($urandom_range(0, 9) < 7);
      pre_edge();
      chk("rnd.ready_in", 32'(ready_in), 32'(m_rdy));
      do_edge();
      chk("rnd.valid_out", 32'(valid_out), 32'(m_valid));
      chk("rnd.data_out", 32'(data_out), 32'(m_data));
      chk("rnd.sel_out", 32'(sel_out), 32'(m_sel));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
